ifmap_loader: RTL and testbench
===============================

// Module: ifmap_loader
// PURPOSE
//  Clocked transmitter for the IMEM load interface. Holds NUM_TS binary ifmaps of DEPTH_I x DEPTH_I
//  spikes, written by the host. On start it streams them to the IMEM load receiver in this order:
//  a START token, then one (timestep, addr, data) entry per pixel for each timestep, then a DONE token.
//  It takes over the stimulus role of the load-phase bench and feeds imem's load_start,
//  timestep/ifmap_addr/ifmap_data and load_done channels through a single valid/ready port.
// PARAMETERS
//  DEPTH_I  25  ifmap side length; a timestep has DEPTH_I*DEPTH_I entries
//  NUM_TS   2   number of timesteps stored and streamed
//  ADDR_W   12  pixel address width (must hold DEPTH_I*DEPTH_I-1)
//  TS_W     2   timestep field width (must hold NUM_TS)
// PORTS
//  clk        in   1       clock, all logic rising-edge
//  reset      in   1       synchronous, active-high
//  wr_en      in   1       host write strobe
//  wr_ts      in   TS_W    host write timestep, 1-based
//  wr_addr    in   ADDR_W  host write pixel address
//  wr_bit     in   1       host write spike value
//  start      in   1       begin one load sequence (single-cycle sample)
//  busy       out  1       sequence in progress
//  done       out  1       one-cycle pulse after the DONE token handshakes
//  out_valid  out  1       token valid
//  out_ready  in   1       receiver accepts the token
//  out_kind   out  2       loader_pkg::kind_t: KIND_START / KIND_ENTRY / KIND_DONE
//  out_ts     out  TS_W    timestep of an entry (1..NUM_TS), 0 for START/DONE
//  out_addr   out  ADDR_W  pixel address of an entry, 0 for START/DONE
//  out_data   out  1       spike value of an entry, 0 for START/DONE
// BEHAVIOUR
//  - Reset: busy=0, done=0, out_valid=0, out_kind=KIND_START, out_ts/out_addr/out_data=0,
//    state=IDLE, bit memory cleared to 0. Reset mid-sequence aborts it; no DONE token and no done pulse.
//  - Writes: when wr_en=1 and busy=0, mem[wr_ts][wr_addr] <= wr_bit. Writes while busy=1 are ignored,
//    as are out-of-range wr_ts (0 or >NUM_TS) and wr_addr >= DEPTH_I*DEPTH_I.
//  - Handshake: a transfer happens on a cycle with out_valid&&out_ready. While valid&&!ready,
//    all out_* fields hold stable. out_valid never drops without a transfer, except on reset.
//  - FSM IDLE -> START -> ENTRY -> DONE -> IDLE:
//    IDLE: start=1 -> START; busy=1 and out_valid=1 with KIND_START on the next cycle.
//          start while busy is ignored.
//    START: on transfer -> ENTRY, ts=1, addr=0.
//    ENTRY: present mem[ts][addr]. On transfer, addr++. When addr==DEPTH_I*DEPTH_I-1, wrap addr to 0
//           and ts++. When ts==NUM_TS also -> DONE.
//    DONE: present KIND_DONE. On transfer -> IDLE, busy=0 and done=1 on the next cycle (one cycle).
//  - Outputs are registered and the next token is prefetched, so with out_ready held at 1 one token
//    transfers per cycle. Total tokens = 2 + NUM_TS*DEPTH_I*DEPTH_I.
//  - Counters wrap only at the stated bounds. The ts/addr registers never exceed NUM_TS or DEPTH_I^2-1.
// CONFIGURATION
//  LOADER_SPARSE_EN defined: in ENTRY, only pixels with mem=1 are emitted, and zero pixels are skipped
//    at one address per cycle with out_valid=0. A timestep with no spikes emits nothing.
//    START and DONE are always sent.
//  Not defined: every pixel is emitted (dense), as described above.
// STRUCTURE
//  - loader_pkg: kind_t {KIND_START=0, KIND_ENTRY=1, KIND_DONE=2} and state_t {IDLE, START, ENTRY, DONE}.
//  - Sub-module ifmap_bitmem: NUM_TS x DEPTH_I^2 bit array with sync write, async read, sync clear.
//    The FSM, counters and output registers live in ifmap_loader.
// TESTING (bench overrides DEPTH_I=3, NUM_TS=2)
//  1 dense: pattern ts1=101010101, ts2=010101010; start; ready=1 -> START, 9 entries (1,0..8),
//    9 entries (2,0..8), DONE over 20 consecutive cycles, then done for 1 cycle.
//  2 backpressure: same pattern, out_ready random 50% -> identical token sequence, fields stable on stalls.
//  3 write while busy: wr (1,4,0) during streaming -> entry (1,4) still reads 1; after idle it reads 0.
//  4 reset after 5 entries -> next cycle out_valid=0, busy=0, no done; restart gives all-zero entries.
//  5 LOADER_SPARSE_EN: only (1,2)=1 and (2,8)=1 set -> START, (1,2,1), (2,8,1), DONE.
//  6 start held high during busy, and during the DONE handshake -> exactly one sequence emitted.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - token kinds and FSM states shared by the ifmap loader
package loader_pkg;

    typedef enum logic [1:0] {
        KIND_START = 2'd0,
        KIND_ENTRY = 2'd1,
        KIND_DONE  = 2'd2
    } kind_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        ENTRY,
        DONE
    } state_t;

endpackage

// File: rtl/ifmap_bitmem.sv
// rtl/ifmap_bitmem.sv - NUM_TS x DEPTH_I^2 spike bit array, sync write/clear, async read
module ifmap_bitmem #(
    parameter int DEPTH_I = 25,
    parameter int NUM_TS  = 2,
    parameter int ADDR_W  = 12,
    parameter int TS_W    = 2
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [TS_W-1:0]   wr_ts,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_bit,
    input  logic [TS_W-1:0]   rd_ts,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bit
);
    localparam int NPIX  = DEPTH_I * DEPTH_I;
    localparam int TOTAL = NUM_TS * NPIX;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic [TOTAL-1:0] bits;

    // Timestep inputs are 0-based here; range checking is the caller's job.
    function automatic logic [IDX_W-1:0] flat_idx(input logic [TS_W-1:0] t,
                                                  input logic [ADDR_W-1:0] a);
        return IDX_W'(t) * IDX_W'(NPIX) + IDX_W'(a);
    endfunction

    always_ff @(posedge clk) begin
        if (clear) begin
            bits <= '0;
        end else if (we) begin
            bits[flat_idx(wr_ts, wr_addr)] <= wr_bit;
        end
    end

    assign rd_bit = bits[flat_idx(rd_ts, rd_addr)];

endmodule

// File: rtl/ifmap_loader.sv
// rtl/ifmap_loader.sv - streams stored ifmaps as START/ENTRY.../DONE tokens; LOADER_SPARSE_EN emits only spikes
module ifmap_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_I = 25,
    parameter int NUM_TS  = 2,
    parameter int ADDR_W  = 12,
    parameter int TS_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [TS_W-1:0]   wr_ts,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_bit,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output kind_t             out_kind,
    output logic [TS_W-1:0]   out_ts,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_data
);
    localparam int NPIX = DEPTH_I * DEPTH_I;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [TS_W-1:0]   LAST_TS   = TS_W'(NUM_TS);

    state_t              state, nxt_state;
    logic [TS_W-1:0]     ts, nxt_ts, rd_ts;
    logic [ADDR_W-1:0]   addr, nxt_addr, rd_addr;
    logic                rd_bit, fire, adv, last, wr_ok, entry_valid;
    logic                nxt_valid, nxt_done, nxt_data;
    kind_t               nxt_kind;
    logic [TS_W-1:0]     nxt_out_ts;
    logic [ADDR_W-1:0]   nxt_out_addr;

    assign busy  = (state != IDLE);
    assign fire  = out_valid && out_ready;
    // A skipped (invalid) pixel advances without a handshake.
    assign adv   = fire || !out_valid;
    assign last  = (ts == LAST_TS) && (addr == LAST_ADDR);
    assign wr_ok = wr_en && !busy && (wr_ts != '0) && (wr_ts <= LAST_TS) && (wr_addr <= LAST_ADDR);

`ifdef LOADER_SPARSE_EN
    assign entry_valid = rd_bit;
`else
    assign entry_valid = 1'b1;
`endif

    // Read port looks one pixel ahead so the next token is ready at handshake.
    always_comb begin
        rd_ts   = TS_W'(1);
        rd_addr = '0;
        if (state == ENTRY && !last) begin
            if (addr == LAST_ADDR) begin
                rd_ts   = ts + TS_W'(1);
                rd_addr = '0;
            end else begin
                rd_ts   = ts;
                rd_addr = addr + ADDR_W'(1);
            end
        end
    end

    ifmap_bitmem #(
        .DEPTH_I(DEPTH_I), .NUM_TS(NUM_TS), .ADDR_W(ADDR_W), .TS_W(TS_W)
    ) u_bitmem (
        .clk     (clk),
        .clear   (reset),
        .we      (wr_ok),
        .wr_ts   (wr_ts - TS_W'(1)),
        .wr_addr (wr_addr),
        .wr_bit  (wr_bit),
        .rd_ts   (rd_ts - TS_W'(1)),
        .rd_addr (rd_addr),
        .rd_bit  (rd_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ts        <= '0;
            addr      <= '0;
            out_valid <= 1'b0;
            out_kind  <= KIND_START;
            out_ts    <= '0;
            out_addr  <= '0;
            out_data  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            ts        <= nxt_ts;
            addr      <= nxt_addr;
            out_valid <= nxt_valid;
            out_kind  <= nxt_kind;
            out_ts    <= nxt_out_ts;
            out_addr  <= nxt_out_addr;
            out_data  <= nxt_data;
            done      <= nxt_done;
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (start)        nxt_state = START;
            START:   if (fire)         nxt_state = ENTRY;
            ENTRY:   if (adv && last)  nxt_state = DONE;
            DONE:    if (fire)         nxt_state = IDLE;
            default:                   nxt_state = IDLE;
        endcase
    end

    always_comb begin
        nxt_ts       = ts;
        nxt_addr     = addr;
        nxt_valid    = out_valid;
        nxt_kind     = out_kind;
        nxt_out_ts   = out_ts;
        nxt_out_addr = out_addr;
        nxt_data     = out_data;
        nxt_done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt_valid    = 1'b1;
                    nxt_kind     = KIND_START;
                    nxt_out_ts   = '0;
                    nxt_out_addr = '0;
                    nxt_data     = 1'b0;
                end
            end
            START, ENTRY: begin
                if ((state == START && fire) || (state == ENTRY && adv && !last)) begin
                    nxt_ts       = rd_ts;
                    nxt_addr     = rd_addr;
                    nxt_valid    = entry_valid;
                    nxt_kind     = KIND_ENTRY;
                    nxt_out_ts   = rd_ts;
                    nxt_out_addr = rd_addr;
                    nxt_data     = rd_bit;
                end else if (state == ENTRY && adv) begin
                    nxt_valid    = 1'b1;
                    nxt_kind     = KIND_DONE;
                    nxt_out_ts   = '0;
                    nxt_out_addr = '0;
                    nxt_data     = 1'b0;
                end
            end
            DONE: begin
                if (fire) begin
                    nxt_valid    = 1'b0;
                    nxt_kind     = KIND_START;
                    nxt_out_ts   = '0;
                    nxt_out_addr = '0;
                    nxt_data     = 1'b0;
                    nxt_done     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ifmap_loader.sv
// tb/tb_ifmap_loader.sv - scoreboard bench for ifmap_loader with DEPTH_I=3, NUM_TS=2
module tb_ifmap_loader;
    import loader_pkg::*;

    localparam int DEPTH_I = 3;
    localparam int NUM_TS  = 2;
    localparam int ADDR_W  = 12;
    localparam int TS_W    = 2;
    localparam int NPIX    = DEPTH_I * DEPTH_I;
`ifdef LOADER_SPARSE_EN
    localparam int DENSE_SPAN = -1;
`else
    localparam int DENSE_SPAN = 2 + NUM_TS * NPIX;
`endif

    logic              clk = 1'b0;
    logic              reset, wr_en, wr_bit, start, out_ready;
    logic [TS_W-1:0]   wr_ts;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy, done, out_valid, out_data;
    kind_t             out_kind;
    logic [TS_W-1:0]   out_ts;
    logic [ADDR_W-1:0] out_addr;

    always #5 clk = ~clk;

    ifmap_loader #(.DEPTH_I(DEPTH_I), .NUM_TS(NUM_TS), .ADDR_W(ADDR_W), .TS_W(TS_W)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ts(wr_ts), .wr_addr(wr_addr),
        .wr_bit(wr_bit), .start(start), .busy(busy), .done(done), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind), .out_ts(out_ts), .out_addr(out_addr),
        .out_data(out_data)
    );

    typedef struct packed {
        logic [1:0]        kind;
        logic [TS_W-1:0]   ts;
        logic [ADDR_W-1:0] addr;
        logic              data;
    } tok_t;

    typedef struct {
        logic [NPIX-1:0] p1;
        logic [NPIX-1:0] p2;
        int              pct;
        int              span;
    } vec_t;

    tok_t exp_q[$];
    vec_t vecs[4];
    int   checks = 0, failures = 0;
    int   ready_pct = 100, cyc = 0, xfers = 0, done_seen = 0;
    int   first_x = -1, last_x = -1, done_cyc = -1;
    bit   stall_pending = 0, mon_en = 1, done_xfer = 0;
    tok_t stall_tok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        tok_t t, e;
        @(negedge clk);
        cyc++;
        t = {out_kind, out_ts, out_addr, out_data};
        if (mon_en) begin
            if (stall_pending) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_fields", t, stall_tok);
            end
            if (done) begin
                done_seen++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("busy_at_done", busy, 0);
                chk("valid_at_done", out_valid, 0);
            end
            if (out_valid && out_ready) begin
                xfers++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
                if (t.kind == 2'd2) done_xfer = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_token actual=%0h required=none", t);
                end else begin
                    e = exp_q.pop_front();
                    chk("token", t, e);
                end
            end
        end
        stall_pending = mon_en && out_valid && !out_ready;
        stall_tok = t;
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(99) < ready_pct);
    endtask

    task automatic push_seq(input logic [NPIX-1:0] p1, input logic [NPIX-1:0] p2);
        tok_t e;
        logic b;
        e = '0;
        exp_q.push_back(e);
        for (int t = 1; t <= NUM_TS; t++) begin
            for (int a = 0; a < NPIX; a++) begin
                b = (t == 1) ? p1[a] : p2[a];
                e.kind = 2'd1; e.ts = TS_W'(t); e.addr = ADDR_W'(a); e.data = b;
`ifdef LOADER_SPARSE_EN
                if (b) exp_q.push_back(e);
`else
                exp_q.push_back(e);
`endif
            end
        end
        e = '0;
        e.kind = 2'd2;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [NPIX-1:0] p1, input logic [NPIX-1:0] p2);
        for (int t = 1; t <= NUM_TS; t++) begin
            for (int a = 0; a < NPIX; a++) begin
                wr_en = 1; wr_ts = TS_W'(t); wr_addr = ADDR_W'(a);
                wr_bit = (t == 1) ? p1[a] : p2[a];
                step();
            end
        end
        wr_en = 0;
    endtask

    task automatic run_seq(input int pct, input int span, input bit hold_start, input bit wr_mid);
        ready_pct = pct;
        out_ready = ($urandom_range(99) < pct);
        xfers = 0; done_seen = 0; first_x = -1; last_x = -1; done_cyc = -1; done_xfer = 0;
        start = 1;
        step();
        if (!hold_start) start = 0;
        for (int c = 0; c < 2000 && done_seen == 0; c++) begin
            if (wr_mid && c == 3) begin wr_en = 1; wr_ts = 1; wr_addr = 4; wr_bit = 0; end
            if (wr_mid && c == 6) wr_en = 0;
            if (done_xfer) start = 0;
            step();
        end
        start = 0; wr_en = 0;
        chk("done_seen", done_seen, 1);
        for (int c = 0; c < 4; c++) step();
        chk("done_once", done_seen, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("busy_idle", busy, 0);
        chk("done_cycle", done_cyc, last_x + 1);
        if (span > 0) chk("span", last_x - first_x + 1, span);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{9'b101010101, 9'b010101010, 100, DENSE_SPAN};
        vecs[1] = '{9'b101010101, 9'b010101010, 50, -1};
        vecs[2] = '{9'b111111111, 9'b000000000, 100, DENSE_SPAN};
        vecs[3] = '{9'b000000100, 9'b100000000, 30, -1};

        reset = 1; wr_en = 0; wr_ts = 0; wr_addr = 0; wr_bit = 0; start = 0; out_ready = 1;
        step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_kind", out_kind, 0);
        chk("rst_fields", {out_ts, out_addr, out_data}, 0);
        reset = 0;
        step();

        for (int i = 0; i < 4; i++) begin
            load(vecs[i].p1, vecs[i].p2);
            push_seq(vecs[i].p1, vecs[i].p2);
            run_seq(vecs[i].pct, vecs[i].span, 0, 0);
        end

        // Write while busy is ignored; the same write when idle lands; bad addresses do nothing.
        load(9'b101010101, 9'b010101010);
        push_seq(9'b101010101, 9'b010101010);
        run_seq(100, DENSE_SPAN, 0, 1);
        wr_en = 1; wr_ts = 1; wr_addr = 4; wr_bit = 0; step();
        wr_ts = 0; wr_addr = 0; wr_bit = 1; step();
        wr_ts = 3; wr_addr = 0; step();
        wr_ts = 1; wr_addr = 9; step();
        wr_en = 0;
        push_seq(9'b101000101, 9'b010101010);
        run_seq(100, DENSE_SPAN, 0, 0);

        // Start held through the DONE handshake yields one sequence.
        push_seq(9'b101000101, 9'b010101010);
        run_seq(60, -1, 1, 0);

        // Reset mid-stream aborts silently and clears the memory.
        load(9'b111111111, 9'b111111111);
        push_seq(9'b111111111, 9'b111111111);
        ready_pct = 100; out_ready = 1; xfers = 0; done_seen = 0;
        start = 1; step(); start = 0;
        for (int c = 0; c < 100 && xfers < 6; c++) step();
        chk("reached_6", xfers, 6);
        mon_en = 0; reset = 1;
        step();
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        reset = 0; exp_q.delete(); mon_en = 1; done_seen = 0;
        for (int c = 0; c < 4; c++) step();
        chk("abort_no_done", done_seen, 0);
        chk("abort_idle_valid", out_valid, 0);
        push_seq(9'b000000000, 9'b000000000);
        run_seq(100, DENSE_SPAN, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
